fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 11 +
 rtl/prefetch_buffer.sv | 33 +++
 rtl/fetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath widths and fetch FSM states.
package cpu_pkg;
  localparam int PC_W   = 8;
  localparam int INSN_W = 16;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetch_state_t;
endpackage

// File: rtl/prefetch_buffer.sv
// Single-entry prefetch buffer: data, address tag and hit compare.
module prefetch_buffer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              fill,
  input  logic [INSN_W-1:0] fill_data,
  input  logic [PC_W-1:0]   fill_addr,
  input  logic [PC_W-1:0]   pc,
  output logic              hit,
  output logic [INSN_W-1:0] data
);
  logic            valid;
  logic [PC_W-1:0] tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end
  end

  assign hit = valid && (tag == pc);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR, fetch FSM with one outstanding request
// and a one-entry prefetch buffer.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PC_CLR,
  input  logic              PC_IC,
  input  logic              IR_LD,
  output logic              IMEM_RD,
  output logic [PC_W-1:0]   IMEM_ADDR,
  input  logic [INSN_W-1:0] IMEM_DATA,
  input  logic              IMEM_VALID,
  output logic [INSN_W-1:0] IR,
  output logic [PC_W-1:0]   PC,
  output logic              IR_VALID,
  output logic              FETCH_BUSY
);
  fetch_state_t      state;
  logic [PC_W-1:0]   req_addr;
  logic              drop;
  logic              ld_pend;
  logic              hit;
  logic [INSN_W-1:0] pb_data;
  logic              ld;
  logic              want;
  logic              accept;

  assign ld   = IR_LD && !PC_CLR;
  assign want = ld || ld_pend;

  // drop remembers a PC_CLR seen while the request was in flight
  assign accept = (state == F_WAIT) && IMEM_VALID &&
                  !PC_CLR && !drop && (req_addr == PC);

  assign IMEM_RD    = !Reset && (state == F_REQ);
  assign IMEM_ADDR  = IMEM_RD ? PC : '0;
  assign FETCH_BUSY = !Reset && ((ld && !hit) || ld_pend);

  prefetch_buffer u_pb (
    .clk       (Clock),
    .rst       (Reset),
    .clr       (PC_CLR),
    .fill      (accept),
    .fill_data (IMEM_DATA),
    .fill_addr (req_addr),
    .pc        (PC),
    .hit       (hit),
    .data      (pb_data)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= F_IDLE;
      req_addr <= '0;
      drop     <= 1'b0;
    end else begin
      unique case (state)
        F_IDLE: begin
          drop <= 1'b0;
          if (!hit && !PC_CLR)
            state <= F_REQ;
        end
        F_REQ: begin
          req_addr <= PC;
          drop     <= PC_CLR;
          state    <= F_WAIT;
        end
        F_WAIT: begin
          if (IMEM_VALID) begin
            drop  <= 1'b0;
            state <= F_IDLE;
          end else if (PC_CLR) begin
            drop <= 1'b1;
          end
        end
        default: state <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      PC       <= '0;
      IR       <= '0;
      IR_VALID <= 1'b0;
      ld_pend  <= 1'b0;
    end else begin
      if (PC_CLR)
        PC <= '0;
      else if (PC_IC)
        PC <= PC + 1'b1;

      if (PC_CLR) begin
        ld_pend <= 1'b0;
      end else if (want && hit) begin
        IR       <= pb_data;
        IR_VALID <= 1'b1;
        ld_pend  <= 1'b0;
      end else if (want && accept) begin
        IR       <= IMEM_DATA;
        IR_VALID <= 1'b1;
        ld_pend  <= 1'b0;
      end else if (ld) begin
        ld_pend <= 1'b1;
      end
    end
  end
endmodule
